// File: rtl/regfile_wb_arb_pkg.sv
// ============================================================================
// Module   : regfile_wb_arb_pkg
// Purpose  : Shared widths, the x0 address constant, the writeback request
//            record and the round-robin pointer encoding for the register-file
//            writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_wb_arb_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_ADDR_W = 5;

    // Address of the hardwired-zero register
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // Which requester wins the next contested cycle
    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter. A lone request is granted directly;
//            on contention the requester named by rr_ptr wins. Every grant
//            hands priority to the other requester, so a loser waits at most
//            one cycle. No grants are issued while rst is high.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import regfile_wb_arb_pkg::*;
#(
    parameter int RESET_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam grant_e RESET_PTR = (RESET_PRIO == 0) ? GRANT_ALU : GRANT_LSU;

    grant_e rr_ptr;
    grant_e rr_ptr_next;

    // Grant decode and pointer advance; the pointer moves on every grant
    always_comb begin
        gnt         = 2'b00;
        rr_ptr_next = rr_ptr;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr_ptr == GRANT_ALU) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        if (gnt[0]) begin
            rr_ptr_next = GRANT_LSU;
        end else if (gnt[1]) begin
            rr_ptr_next = GRANT_ALU;
        end
    end

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= RESET_PTR;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Shares the register-file write port between the ALU (wb0) and
//            load-unit (wb1) writeback sources. One request per cycle is
//            accepted, round-robin on contention, and issued through a
//            registered write port one cycle later. Writes to x0 are accepted
//            but never issued. Read-after-write hazards against the decode
//            read addresses raise raw_stall.
// Options  : REGFILE_WB_ARB_FWD_EN - adds rs1/rs2 forwarding of the value
//            sitting on the write port; that case then no longer stalls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import regfile_wb_arb_pkg::*;
#(
    parameter int DATA_W     = REG_DATA_W,
    parameter int ADDR_W     = REG_ADDR_W,
    parameter int RESET_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              raw_stall,
`ifdef REGFILE_WB_ARB_FWD_EN
    output logic              rs1_fwd_valid,
    output logic [DATA_W-1:0] rs1_fwd_data,
    output logic              rs2_fwd_valid,
    output logic [DATA_W-1:0] rs2_fwd_data,
`endif
    output logic              rd_wren,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic [1:0]        gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    rr_arb2 #(
        .RESET_PRIO (RESET_PRIO)
    ) u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .req ({wb1_valid, wb0_valid}),
        .gnt (gnt)
    );

    assign wb0_ready = gnt[0];
    assign wb1_ready = gnt[1];

    assign sel_addr = gnt[1] ? wb1_addr : wb0_addr;
    assign sel_data = gnt[1] ? wb1_data : wb0_data;

    // Write-port register: load on any grant, but only enable for non-x0 targets
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_wren <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else if (gnt != 2'b00) begin
            rd_wren <= (sel_addr != ZERO_ADDR);
            rd_addr <= sel_addr;
            rd_data <= sel_data;
        end else begin
            rd_wren <= 1'b0;
        end
    end

    // Hazard terms: the write port in flight, and any live request (granted or not)
    logic rs1_nz, rs2_nz;
    logic rs1_hit_port, rs2_hit_port;
    logic rs1_hit_req, rs2_hit_req;

    assign rs1_nz       = (rs1_addr != ZERO_ADDR);
    assign rs2_nz       = (rs2_addr != ZERO_ADDR);
    assign rs1_hit_port = rd_wren && (rd_addr == rs1_addr);
    assign rs2_hit_port = rd_wren && (rd_addr == rs2_addr);
    assign rs1_hit_req  = (wb0_valid && (wb0_addr == rs1_addr)) ||
                          (wb1_valid && (wb1_addr == rs1_addr));
    assign rs2_hit_req  = (wb0_valid && (wb0_addr == rs2_addr)) ||
                          (wb1_valid && (wb1_addr == rs2_addr));

`ifdef REGFILE_WB_ARB_FWD_EN
    // Port-register hits are forwarded instead of stalling
    assign rs1_fwd_valid = !rst && rs1_nz && rs1_hit_port;
    assign rs2_fwd_valid = !rst && rs2_nz && rs2_hit_port;
    assign rs1_fwd_data  = rs1_fwd_valid ? rd_data : '0;
    assign rs2_fwd_data  = rs2_fwd_valid ? rd_data : '0;
    assign raw_stall     = !rst && ((rs1_nz && rs1_hit_req) ||
                                    (rs2_nz && rs2_hit_req));
`else
    assign raw_stall     = !rst && ((rs1_nz && (rs1_hit_port || rs1_hit_req)) ||
                                    (rs2_nz && (rs2_hit_port || rs2_hit_req)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed self-checking bench for regfile_wb_arbiter with a
//            behavioural register file hanging off the write port.
// Options  : REGFILE_WB_ARB_FWD_EN - also checks the forwarding outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb0_valid, wb1_valid;
    logic        wb0_ready, wb1_ready;
    logic [4:0]  wb0_addr, wb1_addr;
    logic [31:0] wb0_data, wb1_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        raw_stall;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
`ifdef REGFILE_WB_ARB_FWD_EN
    logic        rs1_fwd_valid, rs2_fwd_valid;
    logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif

    int total = 0;
    int bad   = 0;
    int k0    = 0;
    int k1    = 0;

    logic [31:0] regs [32] = '{default: 32'h0};

    regfile_wb_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .RESET_PRIO (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb0_valid (wb0_valid),
        .wb0_ready (wb0_ready),
        .wb0_addr  (wb0_addr),
        .wb0_data  (wb0_data),
        .wb1_valid (wb1_valid),
        .wb1_ready (wb1_ready),
        .wb1_addr  (wb1_addr),
        .wb1_data  (wb1_data),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .raw_stall (raw_stall),
`ifdef REGFILE_WB_ARB_FWD_EN
        .rs1_fwd_valid (rs1_fwd_valid),
        .rs1_fwd_data  (rs1_fwd_data),
        .rs2_fwd_valid (rs2_fwd_valid),
        .rs2_fwd_data  (rs2_fwd_data),
`endif
        .rd_wren   (rd_wren),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    // Register file captures the write port on each rising edge
    always @(posedge clk) begin
        if (rd_wren) regs[rd_addr] <= rd_data;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
    endtask

    initial begin
        // Reset with both requests pending and a would-be hazard on rs1
        rst = 1'b1;
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        rs1_addr = 5'd1;
        rs2_addr = 5'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_rdy0",  {31'b0, wb0_ready}, 32'd0);
            chk("rst_rdy1",  {31'b0, wb1_ready}, 32'd0);
            chk("rst_wren",  {31'b0, rd_wren},   32'd0);
            chk("rst_addr",  {27'b0, rd_addr},   32'd0);
            chk("rst_data",  rd_data,            32'd0);
            chk("rst_stall", {31'b0, raw_stall}, 32'd0);
        end
        rst = 1'b0;
        rs1_addr = 5'd0;

        // Contention: grants alternate 0,1,0,1 starting with wb0
        for (int i = 0; i < 4; i++) begin
            wb0_data = 32'h11 + 32'h100 * k0;
            wb1_data = 32'h22 + 32'h100 * k1;
            #1;
            chk("cont_rdy0", {31'b0, wb0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_rdy1", {31'b0, wb1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            chk("cont_wren", {31'b0, rd_wren}, 32'd1);
            chk("cont_addr", {27'b0, rd_addr}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_data", rd_data,
                (i % 2 == 0) ? 32'h11 + 32'h100 * k0 : 32'h22 + 32'h100 * k1);
            if (i % 2 == 0) k0++; else k1++;
        end

        // Idle: write enable drops, address holds
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("idle_wren", {31'b0, rd_wren}, 32'd0);
        chk("idle_addr", {27'b0, rd_addr}, 32'd2);

        // Single source: x5 = DEADBEEF
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        #1;
        chk("single_rdy0", {31'b0, wb0_ready}, 32'd1);
        tick();
        chk("single_wren", {31'b0, rd_wren}, 32'd1);
        chk("single_addr", {27'b0, rd_addr}, 32'd5);
        chk("single_data", rd_data, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("single_reg5", regs[5], 32'hDEADBEEF);

        // x0 write from wb1: accepted but never issued
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        chk("x0_rdy1", {31'b0, wb1_ready}, 32'd1);
        tick();
        chk("x0_wren", {31'b0, rd_wren}, 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("x0_reg0", regs[0], 32'h0);

        // Same address from both: wb0 first (pointer back on wb0), then wb1
        drive(1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 32'h5555FFFF);
        rs1_addr = 5'd7;
        #1;
        chk("same_rdy0",  {31'b0, wb0_ready}, 32'd1);
        chk("same_rdy1",  {31'b0, wb1_ready}, 32'd0);
        chk("same_stall", {31'b0, raw_stall}, 32'd1);
        tick();
        chk("same_data0", rd_data, 32'hAAAA0000);
        wb0_valid = 1'b0;
        #1;
        chk("same_rdy1b", {31'b0, wb1_ready}, 32'd1);
        tick();
        chk("same_addr1", {27'b0, rd_addr}, 32'd7);
        chk("same_data1", rd_data, 32'h5555FFFF);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rs1_addr = 5'd0;
        tick();
        chk("same_reg7", regs[7], 32'h5555FFFF);

        // Hazards: put pointer on wb1, then wb0 loses on x9
        drive(1'b1, 5'd10, 32'hA, 1'b0, 5'd0, 32'h0);
        tick();
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 32'h33);
        rs1_addr = 5'd9;
        rs2_addr = 5'd0;
        #1;
        chk("haz_rdy0",   {31'b0, wb0_ready}, 32'd0);
        chk("haz_rdy1",   {31'b0, wb1_ready}, 32'd1);
        chk("haz_pend",   {31'b0, raw_stall}, 32'd1);
        rs1_addr = 5'd0;
        #1;
        chk("haz_none",   {31'b0, raw_stall}, 32'd0);
        rs2_addr = 5'd3;
        #1;
        chk("haz_gnt",    {31'b0, raw_stall}, 32'd1);
        tick();
        wb1_valid = 1'b0;
        rs1_addr  = 5'd3;
        rs2_addr  = 5'd0;
        #1;
        chk("haz_rdy0b",  {31'b0, wb0_ready}, 32'd1);
`ifdef REGFILE_WB_ARB_FWD_EN
        chk("fwd_stall",  {31'b0, raw_stall},     32'd0);
        chk("fwd1_valid", {31'b0, rs1_fwd_valid}, 32'd1);
        chk("fwd1_data",  rs1_fwd_data,           32'h33);
        chk("fwd2_valid", {31'b0, rs2_fwd_valid}, 32'd0);
`else
        chk("haz_port",   {31'b0, raw_stall}, 32'd1);
`endif
        tick();
        chk("haz_data9",  rd_data, 32'h99);
        wb0_valid = 1'b0;
        rs1_addr  = 5'd0;
        rs2_addr  = 5'd9;
        #1;
`ifdef REGFILE_WB_ARB_FWD_EN
        chk("fwd_stall2", {31'b0, raw_stall},     32'd0);
        chk("fwd2_valid", {31'b0, rs2_fwd_valid}, 32'd1);
        chk("fwd2_data",  rs2_fwd_data,           32'h99);
`else
        chk("haz_port2",  {31'b0, raw_stall}, 32'd1);
`endif
        tick();
        chk("haz_idle",   {31'b0, raw_stall}, 32'd0);

        // x0 pending on both sides: rs=0 never stalls; pointer is on wb1
        drive(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2);
        rs2_addr = 5'd0;
        #1;
        chk("x0p_rdy1",  {31'b0, wb1_ready}, 32'd1);
        chk("x0p_stall", {31'b0, raw_stall}, 32'd0);
        tick();
        chk("x0p_wren",  {31'b0, rd_wren}, 32'd0);
        wb1_valid = 1'b0;
        tick();
        chk("x0p_wren2", {31'b0, rd_wren}, 32'd0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        chk("x0p_reg0",  regs[0], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
